// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches a multiplexed 4-digit 7-segment display bus (segment pattern plus a
// one-hot digit select) and reconstructs the displayed number as four BCD
// nibbles. Each {dig_sel, seg} pair must be held for STABLE_CYCLES edges
// before it is sampled, which filters out scan transitions and ghosting.
// Digits are accepted strictly in order 0,1,2,3; a complete frame is published
// atomically. Out-of-order digits or malformed selects abort the frame.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   seg[6:0]    in   segment pattern, seg[6]=a ... seg[0]=g, active-high
//   dig_sel[3:0] in  one-hot digit enable, 4'b0000 = blanking
//   bcd_out[15:0] out last complete frame, digit 3 in [15:12] ... digit 0 in [3:0]
//   seg_err[3:0] out per-digit illegal-pattern flags for the last frame
//   frame_valid out  one-cycle pulse when bcd_out/seg_err are updated
//   sel_err     out  one-cycle pulse, sampled dig_sel was not one-hot
//   seq_err     out  one-cycle pulse, digit sampled out of order
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] bcd_out,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        sel_err,
  output logic        seq_err
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  localparam logic [3:0] CNT_MAX  = 4'(STABLE_CYCLES);
  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  // Segment pattern -> {illegal, nibble}; illegal patterns map to 4'hF.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      default:    r = 5'h1F;
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] s);
    logic [1:0] r;
    case (s)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // ---- stage p0: input register and stability counter ----
  logic [10:0] in_p0;
  logic [3:0]  cnt_p0;
  logic        changed;
  logic        strobe;

  assign changed = ({dig_sel, seg} != in_p0);
  // Fires on the single edge where the counter reaches STABLE_CYCLES; once
  // saturated it stays quiet until the pair changes.
  assign strobe  = !changed && (cnt_p0 == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p0  <= '0;
      cnt_p0 <= '0;
    end else begin
      in_p0 <= {dig_sel, seg};
      if (changed)
        cnt_p0 <= '0;
      else if (cnt_p0 < CNT_MAX)
        cnt_p0 <= cnt_p0 + 4'd1;
    end
  end

  // Sampled pair is taken from the register; it equals the live input
  // whenever strobe is high.
  logic [3:0] smp_sel;
  logic [4:0] smp_dec;
  logic [1:0] smp_idx;
  logic       smp_ok;
  logic       smp_bad;

  assign smp_sel = in_p0[10:7];
  assign smp_dec = seg_decode(in_p0[6:0]);
  assign smp_idx = onehot_idx(smp_sel);
  assign smp_ok  = strobe && is_onehot(smp_sel);
  assign smp_bad = strobe && (smp_sel != 4'd0) && !is_onehot(smp_sel);

  // ---- stage p1: frame assembly FSM and published outputs ----
  state_t     state;
  logic [1:0] exp_idx;
  logic [15:0] dbuf;
  logic [3:0]  ebuf;
  logic        store_en;

  always_comb begin
    store_en = 1'b0;
    if (smp_ok) begin
      if (state == HUNT)
        store_en = (smp_idx == 2'd0);
      else if (state == COLLECT)
        store_en = (smp_idx == 2'd0) || (smp_idx == exp_idx);
    end
  end

  // Partial-frame buffer is never visible; stale slots are always rewritten
  // before a publish, so it carries no reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      dbuf[{smp_idx, 2'b00} +: 4] <= smp_dec[3:0];
      ebuf[smp_idx]               <= smp_dec[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      exp_idx     <= 2'd0;
      bcd_out     <= 16'h0000;
      seg_err     <= 4'b0000;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seq_err     <= 1'b0;
      case (state)
        HUNT: begin
          if (smp_bad) begin
            sel_err <= 1'b1;
          end else if (smp_ok && smp_idx == 2'd0) begin
            exp_idx <= 2'd1;
            state   <= COLLECT;
          end
        end
        COLLECT: begin
          if (smp_bad) begin
            sel_err <= 1'b1;
            exp_idx <= 2'd0;
            state   <= HUNT;
          end else if (smp_ok) begin
            if (smp_idx == 2'd0) begin
              // Resync on a fresh digit 0 without flagging an error.
              exp_idx <= 2'd1;
            end else if (smp_idx == exp_idx) begin
              if (smp_idx == 2'd3) begin
                // Digit 3 goes straight to the outputs alongside the buffer.
                bcd_out     <= {smp_dec[3:0], dbuf[11:0]};
                seg_err     <= {smp_dec[4], ebuf[2:0]};
                frame_valid <= 1'b1;
                exp_idx     <= 2'd0;
                state       <= PUBLISH;
              end else begin
                exp_idx <= exp_idx + 2'd1;
              end
            end else begin
              seq_err <= 1'b1;
              exp_idx <= 2'd0;
              state   <= HUNT;
            end
          end
        end
        PUBLISH: begin
          state <= HUNT;
        end
        default: begin
          exp_idx <= 2'd0;
          state   <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed-vector bench for seg7_scan_decoder: drives digit scans and checks
// published frames, error pulses and reset behaviour against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        sel_err;
  logic        seq_err;

  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PBAD = 7'b0000001;

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .seg_err     (seg_err),
    .frame_valid (frame_valid),
    .sel_err     (sel_err),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled on the falling edge (one count per high cycle).
  int fv_cnt  = 0;
  int sel_cnt = 0;
  int seq_cnt = 0;
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (sel_err)     sel_cnt++;
    if (seq_err)     seq_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold one digit for 6 cycles, then blank for 2; changes land on negedge.
  task automatic show(input logic [3:0] sel, input logic [6:0] pat, input int hold);
    @(negedge clk);
    dig_sel = sel;
    seg     = pat;
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    dig_sel = 4'b0000;
    seg     = 7'b0000000;
    repeat (1) @(negedge clk);
  endtask

  task automatic digit(input int idx, input logic [6:0] pat);
    show(4'b0001 << idx, pat, 6);
  endtask

  int fv0, sel0, seq0;

  task automatic snap();
    fv0  = fv_cnt;
    sel0 = sel_cnt;
    seq0 = seq_cnt;
  endtask

  initial begin
    rst_n   = 1'b0;
    seg     = 7'b0000000;
    dig_sel = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_bcd",  32'(bcd_out), 32'h0000);
    check("reset_serr", 32'(seg_err), 32'h0);
    check("reset_fv",   32'(frame_valid), 32'h0);
    check("reset_selerr", 32'(sel_err), 32'h0);
    check("reset_seqerr", 32'(seq_err), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame 4321
    snap();
    digit(0, P1); digit(1, P2); digit(2, P3); digit(3, P4);
    check("f4321_fv",   32'(fv_cnt - fv0), 32'd1);
    check("f4321_bcd",  32'(bcd_out), 32'h4321);
    check("f4321_serr", 32'(seg_err), 32'h0);
    check("f4321_noerr", 32'(sel_cnt - sel0 + seq_cnt - seq0), 32'd0);

    // Illegal pattern on digit 2
    snap();
    digit(0, P1); digit(1, P2); digit(2, PBAD); digit(3, P4);
    check("bad2_fv",   32'(fv_cnt - fv0), 32'd1);
    check("bad2_bcd",  32'(bcd_out), 32'h4F21);
    check("bad2_serr", 32'(seg_err), 32'b0100);

    // Skipped digit 2 aborts the frame
    snap();
    digit(0, P9); digit(1, P9); digit(3, P9);
    check("skip_seq", 32'(seq_cnt - seq0), 32'd1);
    check("skip_fv",  32'(fv_cnt - fv0), 32'd0);
    check("skip_bcd", 32'(bcd_out), 32'h4F21);
    check("skip_serr", 32'(seg_err), 32'b0100);

    // Non-one-hot select: long dwell errors, short glitch does not
    snap();
    show(4'b0110, P8, 6);
    check("sel_long", 32'(sel_cnt - sel0), 32'd1);
    snap();
    show(4'b0110, P8, 2);
    repeat (4) @(negedge clk);
    check("sel_glitch", 32'(sel_cnt - sel0), 32'd0);

    // Resync on digit 0 mid-frame
    snap();
    digit(0, P1); digit(1, P1);
    digit(0, P9); digit(1, P8); digit(2, P7); digit(3, P6);
    check("resync_seq", 32'(seq_cnt - seq0), 32'd0);
    check("resync_fv",  32'(fv_cnt - fv0), 32'd1);
    check("resync_bcd", 32'(bcd_out), 32'h6789);
    check("resync_serr", 32'(seg_err), 32'h0);

    // Reset mid-frame, then a fresh frame
    digit(0, P2); digit(1, P2); digit(2, P2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_bcd",  32'(bcd_out), 32'h0000);
    check("midrst_serr", 32'(seg_err), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap();
    // A lone digit 3 after reset must not complete the discarded frame.
    digit(3, P2);
    check("postrst_d3_fv",  32'(fv_cnt - fv0), 32'd0);
    check("postrst_d3_seq", 32'(seq_cnt - seq0), 32'd0);
    digit(0, P5); digit(1, P5); digit(2, P5); digit(3, P5);
    check("postrst_fv",  32'(fv_cnt - fv0), 32'd1);
    check("postrst_bcd", 32'(bcd_out), 32'h5555);

    // Blanking dwell on its own raises nothing and keeps the frame
    snap();
    repeat (10) @(negedge clk);
    check("blank_quiet", 32'(fv_cnt - fv0 + sel_cnt - sel0 + seq_cnt - seq0), 32'd0);
    check("blank_hold",  32'(bcd_out), 32'h5555);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
